bcd_display_driver: RTL

//  Converts the calculator's 8-bit unsigned magnitude plus sign flag into three BCD digits

---
 rtl/bcd_display_driver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: converts an unsigned magnitude plus a sign flag into three
// BCD digits with an iterative double-dabble sequence. The result is held in
// display registers. Seven-segment codes are then driven for the digit that the
// upstream scan FSM selects.
module bcd_display_driver #(
  parameter int WIDTH          = 8,   // magnitude width, 4..9
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic             slow_clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             negative,
  input  logic [1:0]       SEL,
  output logic [6:0]       SEG,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [3:0] COUNT_INIT = 4'(WIDTH);

  logic [0:0]       state;
  logic [3:0]       count;
  logic [WIDTH-1:0] bin;
  logic [11:0]      scratch;
  logic             sign_cap;
  logic [3:0]       disp_h, disp_t, disp_o;
  logic             disp_sign;

  logic [11:0]      adj;
  logic [11:0]      scratch_next;
  logic [WIDTH-1:0] bin_next;

  // Seven-segment code {g..a}, active high, for one BCD digit.
  function automatic logic [6:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0:    digit_code = 7'h3F;
      4'd1:    digit_code = 7'h06;
      4'd2:    digit_code = 7'h5B;
      4'd3:    digit_code = 7'h4F;
      4'd4:    digit_code = 7'h66;
      4'd5:    digit_code = 7'h6D;
      4'd6:    digit_code = 7'h7D;
      4'd7:    digit_code = 7'h07;
      4'd8:    digit_code = 7'h7F;
      4'd9:    digit_code = 7'h6F;
      default: digit_code = 7'h00;
    endcase
  endfunction

  // Double-dabble step: add 3 to every nibble >= 5. The shift follows below.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3
                                                   : scratch[4*i +: 4];
    end
  end

  assign {scratch_next, bin_next} = {adj[10:0], bin, 1'b0};

  assign busy = (state == SHIFT);

  // Control FSM, shift counter and display registers.
  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      done      <= 1'b0;
      disp_h    <= 4'd0;
      disp_t    <= 4'd0;
      disp_o    <= 4'd0;
      disp_sign <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            count <= COUNT_INIT;
          end
        end
        SHIFT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state     <= IDLE;
            disp_h    <= scratch_next[11:8];
            disp_t    <= scratch_next[7:4];
            disp_o    <= scratch_next[3:0];
            disp_sign <= sign_cap;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Conversion datapath: loaded on an accepted start, shifted while in SHIFT.
  // NOTE: the datapath is left without a reset. Every conversion reloads it before use, so
  // its contents after reset are never observed.
  always_ff @(posedge slow_clock) begin
    if (state == IDLE && start) begin
      bin      <= value;
      scratch  <= 12'd0;
      sign_cap <= negative;
    end else if (state == SHIFT) begin
      bin     <= bin_next;
      scratch <= scratch_next;
    end
  end

  // Segment decode for the selected digit, with leading-zero blanking.
  // NOTE: code gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [6:0] code;
    logic       hund_blank;
    logic       tens_blank;
    code       = 7'h00;
    hund_blank = BLANK_LZ && (disp_h == 4'd0);
    tens_blank = BLANK_LZ && (disp_h == 4'd0) && (disp_t == 4'd0);
    case (SEL)
      2'b00:   code = disp_sign ? 7'h40 : 7'h00;
      2'b01:   code = hund_blank ? 7'h00 : digit_code(disp_h);
      2'b10:   code = tens_blank ? 7'h00 : digit_code(disp_t);
      default: code = digit_code(disp_o);
    endcase
    SEG = SEG_ACTIVE_LOW ? ~code : code;
  end

endmodule
